sha_host_ctrl: RTL
==================

# sha_host_ctrl

Host-side controller for the SHA engine's shared data memory and start/stop handshake. It accepts a message as a 32-bit word stream and writes it into data memory. It then starts the engine and waits for completion, and finally reads the digest words back out of data memory as an output stream. It sits between the system bus adapter and the data BRAM/engine pair, owning the memory port whenever the engine is idle.

## Interface
- MAX_WORDS, 511, maximum message words accepted (≤ 511, fits the 9-bit length)
- DIGEST_BASE, 9'd0, data-memory word address of the first digest word
- DIGEST_WORDS, 5, number of digest words read back
- TIMEOUT, 65535, maximum cycles in WAIT before error (16-bit counter)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  message word valid
- in_ready  out  1  controller accepts word
- in_data  in  32  message word
- in_last  in  1  final word of message
- mem_sel  out  1  1 = controller owns data-memory port, 0 = engine owns it
- mem_addr  out  9  data-memory address
- mem_we  out  1  data-memory write enable
- mem_wdata  out  32  data-memory write data
- mem_rdata  in  32  data-memory read data, valid 1 cycle after address
- length  out  9  number of message words loaded, held from LOAD end until next message
- start  out  2  engine start code: 2'b01 = run, 2'b00 = idle
- stop  in  3  engine status: nonzero = finished; stop[2]=1 = engine error
- out_valid  out  1  digest word valid
- out_ready  in  1  consumer accepts digest word
- out_data  out  32  digest word
- out_last  out  1  final digest word
- busy  out  1  high in every state except IDLE
- err  out  1  sticky error; cleared when the first word of a new message is accepted

## Operation
- States: IDLE, LOAD, START, WAIT, RADDR, RDATA, ROUT, ERR.
- IDLE: in_ready=1, mem_sel=1. An accepted word (in_valid & in_ready) does the following:
  - writes to address 0;
  - sets the word count to 1 and clears err;
  - goes to LOAD, or to START if in_last is set.
- LOAD: in_ready=1. Each accepted word is written at address = count, and count increments.
  - in_last accepted → START.
  - count reaching MAX_WORDS without in_last → ERR. The offending word is not written.
- Writes are combinational on acceptance: mem_we = in_valid & in_ready, mem_addr = count, mem_wdata = in_data.
- START: length ← count, mem_sel ← 0, start ← 2'b01, timeout counter cleared → WAIT.
- WAIT: start held at 2'b01 and the counter increments.
  - stop≠0 with stop[2]=0 → start ← 2'b00, mem_sel ← 1, read index ← 0 → RADDR.
  - stop[2]=1, or counter = TIMEOUT → ERR.
- RADDR: mem_addr = DIGEST_BASE + index (9-bit wrap) → RDATA.
- RDATA: capture mem_rdata into the output register → ROUT.
- ROUT: out_valid=1, out_last = (index = DIGEST_WORDS−1).
  - On out_ready: if out_last → IDLE, else index+1 → RADDR.
- ERR: err ← 1, start ← 2'b00, mem_sel ← 1, in_ready=0 for one cycle → IDLE.
- in_ready=0 in every state except IDLE and LOAD. out_valid=0 except in ROUT.
- Once out_valid is raised, out_data and out_last stay stable until accepted.

## Timing
- Reset (reset=0, asynchronous) gives:
  - state IDLE;
  - in_ready=1, mem_sel=1, mem_we=0, mem_addr=0, mem_wdata=0;
  - length=0, start=2'b00, out_valid=0, out_data=0, out_last=0, busy=0, err=0.
- Reset asserted mid-operation drops start and out_valid immediately and returns memory ownership to the controller.
- One word is accepted per cycle while in_valid=1. An n-word message occupies n cycles of LOAD/IDLE acceptance, then 1 cycle in START.
- start rises the cycle after START is entered. It falls the cycle after stop≠0 is sampled.
- Each digest word takes at least 3 cycles (RADDR, RDATA, ROUT). The first out_valid comes 3 cycles after the stop≠0 sample.
- stop≠0 and timeout in the same cycle: stop takes priority (RADDR, or ERR if stop[2]=1).
- stop is ignored outside WAIT.

## Test plan
- Reset value check: reset low mid-WAIT → start=2'b00, busy=0, err=0, in_ready=1 immediately.
- 3-word message 32'h61626380, 0, 0 with last on word 3:
  - writes land at addresses 0..2, length=3, start=01;
  - stop=3'b001 after 10 cycles → 5 words from DIGEST_BASE streamed, out_last on the 5th.
- Backpressure: out_ready held low 4 cycles in ROUT → out_data stable and no index advance; then 5 words delivered in order.
- Overflow: 511 words without last → ERR, err=1, no write at address 511, back in IDLE. The next message's first word clears err.
- Engine error: stop=3'b100 in WAIT → err=1, start drops, no output words.
- Timeout: TIMEOUT=16, stop held 0 → ERR exactly 17 cycles after WAIT entry. With stop=3'b001 arriving on the timeout cycle → normal readback, err=0.

Source files
------------

// File: rtl/sha_host_ctrl.sv
// sha_host_ctrl: loads a message into the SHA data BRAM, runs the engine,
// then streams the digest words back out of the BRAM.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_data/in_last     message word stream
//   mem_sel/mem_addr/mem_we/mem_wdata/mem_rdata
//                                         data-memory port (1-cycle read latency)
//   length/start/stop                     engine handshake
//   out_valid/out_ready/out_data/out_last digest word stream
//   busy/err                              status
module sha_host_ctrl #(
    parameter int unsigned MAX_WORDS    = 511,
    parameter logic [8:0]  DIGEST_BASE  = 9'd0,
    parameter int unsigned DIGEST_WORDS = 5,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        mem_sel,
    output logic [8:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [8:0]  length,
    output logic [1:0]  start,
    input  logic [2:0]  stop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    localparam logic [8:0]  MAX_W    = 9'(MAX_WORDS);
    localparam logic [8:0]  LAST_IDX = 9'(DIGEST_WORDS - 1);
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RADDR,
        S_RDATA,
        S_ROUT,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [8:0]  r_count;
    logic [8:0]  r_idx;
    logic [8:0]  r_length;
    logic [15:0] r_tmo;
    logic [1:0]  r_start;
    logic        r_mem_sel;
    logic        r_out_valid;
    logic        r_out_last;
    logic [31:0] r_out_data;
    logic        r_err;

    logic        w_load;
    logic        w_acc;
    logic        w_stop;
    logic [8:0]  w_cnt_nxt;

    // IDLE and LOAD both take message words; the first word always
    // lands at address 0 regardless of the previous message's count.
    assign w_load    = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_acc     = in_valid & w_load;
    assign w_cnt_nxt = (r_state == S_IDLE) ? 9'd1 : r_count + 9'd1;
    assign w_stop    = |stop;

    assign in_ready  = w_load;
    assign mem_we    = w_acc;
    assign mem_wdata = w_acc ? in_data : 32'd0;
    assign mem_addr  = (r_state == S_LOAD)  ? r_count :
                       (r_state == S_RADDR) ? DIGEST_BASE + r_idx :
                       9'd0;

    assign mem_sel   = r_mem_sel;
    assign length    = r_length;
    assign start     = r_start;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= 9'd0;
            r_idx       <= 9'd0;
            r_length    <= 9'd0;
            r_tmo       <= 16'd0;
            r_start     <= 2'b00;
            r_mem_sel   <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_acc) begin
                        r_count <= w_cnt_nxt;
                        if (r_state == S_IDLE) begin
                            r_err <= 1'b0;
                        end
                        // A full buffer without in_last is an overflow;
                        // ERR refuses the next word so address MAX_W is never written.
                        if (in_last) begin
                            r_state <= S_START;
                        end else if (w_cnt_nxt == MAX_W) begin
                            r_state <= S_ERR;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    r_length  <= r_count;
                    r_mem_sel <= 1'b0;
                    r_start   <= 2'b01;
                    r_tmo     <= 16'd0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_tmo <= r_tmo + 16'd1;
                    // stop outranks a coincident timeout
                    if (w_stop && !stop[2]) begin
                        r_start   <= 2'b00;
                        r_mem_sel <= 1'b1;
                        r_idx     <= 9'd0;
                        r_state   <= S_RADDR;
                    end else if (w_stop || (r_tmo == TMO_MAX)) begin
                        r_start   <= 2'b00;
                        r_mem_sel <= 1'b1;
                        r_state   <= S_ERR;
                    end
                end
                S_RADDR: begin
                    r_state <= S_RDATA;
                end
                S_RDATA: begin
                    r_out_data  <= mem_rdata;
                    r_out_last  <= (r_idx == LAST_IDX);
                    r_out_valid <= 1'b1;
                    r_state     <= S_ROUT;
                end
                S_ROUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 9'd1;
                            r_state <= S_RADDR;
                        end
                    end
                end
                S_ERR: begin
                    r_err     <= 1'b1;
                    r_start   <= 2'b00;
                    r_mem_sel <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
